io_bus_arbiter: RTL and testbench
=================================

IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 Parameter: RD_WAIT, default 0, range 0..7; wait cycles between the read strobe and read-data sampling.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 m0_req, m1_req  input  1 each  master request; master 0 is the CPU, master 1 is DMA.
REQ-005 m0_wr, m1_wr  input  1 each  1 = write, 0 = read.
REQ-006 m0_addr, m1_addr  input  32 each  byte address, passed to the bus unchanged.
REQ-007 m0_wr_data, m1_wr_data  input  32 each  write data.
REQ-008 m0_gnt, m1_gnt  output  1 each  one-cycle command-accepted pulse.
REQ-009 m0_rd_valid, m1_rd_valid  output  1 each  one-cycle read-data-valid pulse.
REQ-010 rd_data  output  32  registered read data, shared by both masters.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 bus_cs, bus_wr, bus_rd  output  1 each  IO bus strobes.
REQ-013 bus_addr, bus_wr_data  output  32 each  IO bus address and write data.
REQ-014 bus_rd_data  input  32  IO bus read data (combinational slot mux).

Function
REQ-015 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-016 IDLE: if any req is high, pick the winner, latch its wr, addr and wr_data at the clock edge, then go to ISSUE; otherwise stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: with both req high, the master not granted last wins; a single requester always wins.
REQ-018 The last-grant pointer SHALL update only on a grant; after reset it favours m0, so m0 wins the first contest.
REQ-019 ISSUE lasts exactly 1 cycle: bus_cs=1, bus_wr=latched wr, bus_rd=~latched wr, and the winner's gnt=1.
REQ-020 A write SHALL go ISSUE->IDLE, for a total of 2 cycles.
REQ-021 A read with RD_WAIT=0 SHALL sample bus_rd_data at the end of ISSUE and go to RESP.
REQ-022 A read with RD_WAIT=N>0 SHALL go ISSUE->WAIT, stay in WAIT for N cycles with the strobes low, sample bus_rd_data at the end of the last WAIT cycle, then go to RESP.
REQ-023 RESP lasts 1 cycle: rd_data holds the sampled value, the winner's rd_valid=1, then the FSM returns to IDLE.
REQ-024 Read latency from the IDLE decision cycle to rd_valid SHALL be 2+RD_WAIT cycles.
REQ-025 bus_addr and bus_wr_data SHALL equal the latched command from ISSUE through the sampling cycle, and SHALL hold that value until the next grant (no toggling).
REQ-026 bus_cs, bus_wr and bus_rd SHALL be high only in ISSUE; they are never high simultaneously for wr and rd.
REQ-027 gnt and rd_valid SHALL never be high for both masters in the same cycle; rd_valid goes only to the master that issued the read.
REQ-028 A master SHALL hold req and its command stable until gnt; a req still high on return to IDLE is treated as a new request.
REQ-029 A req that drops before being selected SHALL be ignored; there is no queueing.
REQ-030 rd_data SHALL hold its value outside RESP until the next read sample.

Reset
REQ-031 On reset low, the FSM SHALL enter IDLE asynchronously.
REQ-032 On reset low, all strobes, gnt, rd_valid and busy SHALL be 0.
REQ-033 On reset low, rd_data, bus_addr and bus_wr_data SHALL be 0, the WAIT counter 0, and the pointer set so m0 has priority.
REQ-034 Reset asserted mid-transaction SHALL abort it with no gnt or rd_valid afterwards; operation resumes on the first edge after reset deasserts.

Verification
REQ-035 Single write: m0 write addr 0x0000_0184, data 0xDEAD_BEEF -> the next cycle has bus_cs=1, bus_wr=1, bus_addr=0x184, m0_gnt=1; idle after 2 cycles.
REQ-036 Read with RD_WAIT=0: m1 read addr 0x200, bus_rd_data=0x1234_5678 -> m1_gnt in ISSUE, m1_rd_valid=1 with rd_data=0x1234_5678 two cycles after request, m0_rd_valid=0.
REQ-037 Contention: m0 and m1 request continuously (writes) from reset -> grants alternate m0, m1, m0, m1, with bus_wr pulses every 2 cycles.
REQ-038 RD_WAIT=3: m0 read, bus_rd_data changes from 0x1 to 0xAA at the last WAIT cycle -> bus_rd exactly 1 cycle, rd_data=0xAA, rd_valid 5 cycles after request.
REQ-039 Reset during WAIT: assert reset in WAIT -> busy=0 and all strobes 0 immediately, no rd_valid; after release, the first contested grant goes to m0.

Source files
------------

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: two-master (CPU = m0, DMA = m1) round-robin arbiter driving a
// simple strobed IO bus. Each command is latched in IDLE, issued for one cycle
// in ISSUE, optionally waits RD_WAIT cycles, and reads return through RESP.
//
// Ports
//   clk, rst_n                          clock, asynchronous active-low reset
//   m{0,1}_req_i / _wr_i                master request and direction (1 = write)
//   m{0,1}_addr_i / _wr_data_i          master command address / write data
//   m{0,1}_gnt_o                        one-cycle command-accepted pulse
//   m{0,1}_rd_valid_o                   one-cycle read-data-valid pulse
//   rd_data_o                           registered read data shared by both masters
//   busy_o                              high whenever the FSM is not in IDLE
//   bus_cs_o / bus_wr_o / bus_rd_o      IO bus strobes (ISSUE only)
//   bus_addr_o / bus_wr_data_o          IO bus address / write data (held until next grant)
//   bus_rd_data_i                       IO bus read data
module io_bus_arbiter #(
  parameter int unsigned RD_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req_i,
  input  logic        m1_req_i,
  input  logic        m0_wr_i,
  input  logic        m1_wr_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m0_wr_data_i,
  input  logic [31:0] m1_wr_data_i,
  output logic        m0_gnt_o,
  output logic        m1_gnt_o,
  output logic        m0_rd_valid_o,
  output logic        m1_rd_valid_o,
  output logic [31:0] rd_data_o,
  output logic        busy_o,
  output logic        bus_cs_o,
  output logic        bus_wr_o,
  output logic        bus_rd_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wr_data_o,
  input  logic [31:0] bus_rd_data_i
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e          state_q;
  logic            wr_q;        // latched direction of the command in flight
  logic            owner_q;     // 1 = m1 owns the command in flight
  logic            prio_m1_q;   // 1 = m1 wins the next contest (m0 was granted last)
  logic [CW-1:0]   wait_cnt_q;

  // Round-robin pick: m1 wins if it is the only requester or it has priority
  logic            pick_m1;
  logic            sel_wr;
  logic [DW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  assign pick_m1   = m1_req_i & (~m0_req_i | prio_m1_q);
  assign sel_wr    = pick_m1 ? m1_wr_i      : m0_wr_i;
  assign sel_addr  = pick_m1 ? m1_addr_i    : m0_addr_i;
  assign sel_wdata = pick_m1 ? m1_wr_data_i : m0_wr_data_i;

  // Arbiter FSM with registered outputs; pulses default low every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_q          <= 1'b0;
      owner_q       <= 1'b0;
      prio_m1_q     <= 1'b0;
      wait_cnt_q    <= '0;
      m0_gnt_o      <= 1'b0;
      m1_gnt_o      <= 1'b0;
      m0_rd_valid_o <= 1'b0;
      m1_rd_valid_o <= 1'b0;
      rd_data_o     <= '0;
      busy_o        <= 1'b0;
      bus_cs_o      <= 1'b0;
      bus_wr_o      <= 1'b0;
      bus_rd_o      <= 1'b0;
      bus_addr_o    <= '0;
      bus_wr_data_o <= '0;
    end else begin
      m0_gnt_o      <= 1'b0;
      m1_gnt_o      <= 1'b0;
      m0_rd_valid_o <= 1'b0;
      m1_rd_valid_o <= 1'b0;
      bus_cs_o      <= 1'b0;
      bus_wr_o      <= 1'b0;
      bus_rd_o      <= 1'b0;

      case (state_q)
        IDLE: begin
          if (m0_req_i || m1_req_i) begin
            owner_q       <= pick_m1;
            prio_m1_q     <= ~pick_m1;
            wr_q          <= sel_wr;
            bus_addr_o    <= sel_addr;
            bus_wr_data_o <= sel_wdata;
            bus_cs_o      <= 1'b1;
            bus_wr_o      <= sel_wr;
            bus_rd_o      <= ~sel_wr;
            m0_gnt_o      <= ~pick_m1;
            m1_gnt_o      <= pick_m1;
            busy_o        <= 1'b1;
            state_q       <= ISSUE;
          end
        end

        ISSUE: begin
          if (wr_q) begin
            busy_o  <= 1'b0;
            state_q <= IDLE;
          end else if (RD_WAIT == 32'd0) begin
            rd_data_o     <= bus_rd_data_i;
            m0_rd_valid_o <= ~owner_q;
            m1_rd_valid_o <= owner_q;
            state_q       <= RESP;
          end else begin
            // Counter holds the number of WAIT cycles still to follow this one
            wait_cnt_q <= CW'(RD_WAIT - 32'd1);
            state_q    <= WAIT;
          end
        end

        WAIT: begin
          if (wait_cnt_q == '0) begin
            rd_data_o     <= bus_rd_data_i;
            m0_rd_valid_o <= ~owner_q;
            m1_rd_valid_o <= owner_q;
            state_q       <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q - CW'(1);
          end
        end

        RESP: begin
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: drives two arbiter instances (RD_WAIT = 0 and 3) with the
// same master/bus stimulus; directed checks on timing plus a read scoreboard.
module tb_io_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m1_req, m0_wr, m1_wr;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, bus_rd_data;

  // Index 0: RD_WAIT = 0 instance, index 1: RD_WAIT = 3 instance
  logic        m0_gnt [2];
  logic        m1_gnt [2];
  logic        m0_rdv [2];
  logic        m1_rdv [2];
  logic        busy   [2];
  logic        cs     [2];
  logic        bwr    [2];
  logic        brd    [2];
  logic [31:0] rd_data[2];
  logic [31:0] baddr  [2];
  logic [31:0] bwdata [2];

  typedef struct packed {
    logic        m1;
    logic [31:0] d;
  } rd_exp_t;

  rd_exp_t exp0_q[$];
  rd_exp_t exp3_q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  io_bus_arbiter #(.RD_WAIT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m1_req_i(m1_req), .m0_wr_i(m0_wr), .m1_wr_i(m1_wr),
    .m0_addr_i(m0_addr), .m1_addr_i(m1_addr),
    .m0_wr_data_i(m0_wdata), .m1_wr_data_i(m1_wdata),
    .m0_gnt_o(m0_gnt[0]), .m1_gnt_o(m1_gnt[0]),
    .m0_rd_valid_o(m0_rdv[0]), .m1_rd_valid_o(m1_rdv[0]),
    .rd_data_o(rd_data[0]), .busy_o(busy[0]),
    .bus_cs_o(cs[0]), .bus_wr_o(bwr[0]), .bus_rd_o(brd[0]),
    .bus_addr_o(baddr[0]), .bus_wr_data_o(bwdata[0]),
    .bus_rd_data_i(bus_rd_data)
  );

  io_bus_arbiter #(.RD_WAIT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m1_req_i(m1_req), .m0_wr_i(m0_wr), .m1_wr_i(m1_wr),
    .m0_addr_i(m0_addr), .m1_addr_i(m1_addr),
    .m0_wr_data_i(m0_wdata), .m1_wr_data_i(m1_wdata),
    .m0_gnt_o(m0_gnt[1]), .m1_gnt_o(m1_gnt[1]),
    .m0_rd_valid_o(m0_rdv[1]), .m1_rd_valid_o(m1_rdv[1]),
    .rd_data_o(rd_data[1]), .busy_o(busy[1]),
    .bus_cs_o(cs[1]), .bus_wr_o(bwr[1]), .bus_rd_o(brd[1]),
    .bus_addr_o(baddr[1]), .bus_wr_data_o(bwdata[1]),
    .bus_rd_data_i(bus_rd_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: every rd_valid pulse must match the oldest pushed expectation
  task automatic mon_rd(input int d);
    rd_exp_t e;
    int      n;
    if (m0_rdv[d] || m1_rdv[d]) begin
      n = (d == 0) ? exp0_q.size() : exp3_q.size();
      if (n == 0) begin
        check($sformatf("rd_unexpected%0d", d), 32'd1, 32'd0);
      end else begin
        if (d == 0) e = exp0_q.pop_front();
        else        e = exp3_q.pop_front();
        check($sformatf("rd_owner%0d", d), 32'({m1_rdv[d], m0_rdv[d]}), e.m1 ? 32'd2 : 32'd1);
        check($sformatf("rd_data%0d", d), rd_data[d], e.d);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int d = 0; d < 2; d++) begin
        check("gnt_excl",   32'(m0_gnt[d] & m1_gnt[d]), 32'd0);
        check("rdv_excl",   32'(m0_rdv[d] & m1_rdv[d]), 32'd0);
        check("wr_rd_excl", 32'(bwr[d] & brd[d]),       32'd0);
        check("strobe_cs",  32'((bwr[d] | brd[d]) & ~cs[d]), 32'd0);
      end
      mon_rd(0);
      mon_rd(1);
    end
  end

  initial begin
    rst_n = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; m0_wr = 1'b0; m1_wr = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    bus_rd_data = '0;

    // Reset state
    step(1);
    for (int d = 0; d < 2; d++) begin
      check("rst_busy",   32'(busy[d]),   32'd0);
      check("rst_cs",     32'(cs[d]),     32'd0);
      check("rst_wr",     32'(bwr[d]),    32'd0);
      check("rst_rd",     32'(brd[d]),    32'd0);
      check("rst_gnt",    32'({m1_gnt[d], m0_gnt[d]}), 32'd0);
      check("rst_rdv",    32'({m1_rdv[d], m0_rdv[d]}), 32'd0);
      check("rst_rdata",  rd_data[d], 32'd0);
      check("rst_addr",   baddr[d],   32'd0);
      check("rst_wdata",  bwdata[d],  32'd0);
    end
    rst_n = 1'b1;

    // Contention from reset: continuous writes from both masters alternate m0, m1, ...
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 32'h100; m0_wdata = 32'hA0A0_0000;
    m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 32'h104; m1_wdata = 32'hB0B0_0000;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      for (int d = 0; d < 2; d++) begin
        logic odd, w;
        odd = (i % 2) == 1;
        w   = (((i - 1) / 2) % 2) == 1;
        check("cont_m0_gnt", 32'(m0_gnt[d]), 32'(odd & ~w));
        check("cont_m1_gnt", 32'(m1_gnt[d]), 32'(odd & w));
        check("cont_bus_wr", 32'(bwr[d]),    32'(odd));
        if (odd) check("cont_addr", baddr[d], w ? 32'h104 : 32'h100);
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    step(1);

    // Single write from m0
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 32'h0000_0184; m0_wdata = 32'hDEAD_BEEF;
    step(1);
    for (int d = 0; d < 2; d++) begin
      check("wr_cs",     32'(cs[d]),     32'd1);
      check("wr_wr",     32'(bwr[d]),    32'd1);
      check("wr_rd",     32'(brd[d]),    32'd0);
      check("wr_addr",   baddr[d],       32'h184);
      check("wr_wdata",  bwdata[d],      32'hDEAD_BEEF);
      check("wr_gnt",    32'({m1_gnt[d], m0_gnt[d]}), 32'd1);
      check("wr_busy",   32'(busy[d]),   32'd1);
    end
    m0_req = 1'b0;
    step(1);
    for (int d = 0; d < 2; d++) begin
      check("wr_idle",      32'(busy[d]), 32'd0);
      check("wr_cs_low",    32'(cs[d]),   32'd0);
      check("wr_addr_hold", baddr[d],     32'h184);
    end

    // m1 read; RD_WAIT=0 answers 2 cycles after request, RD_WAIT=3 after 5
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 32'h200; bus_rd_data = 32'h1234_5678;
    exp0_q.push_back('{m1: 1'b1, d: 32'h1234_5678});
    exp3_q.push_back('{m1: 1'b1, d: 32'h1234_5678});
    step(1);
    for (int d = 0; d < 2; d++) begin
      check("rd1_gnt",  32'({m1_gnt[d], m0_gnt[d]}), 32'd2);
      check("rd1_strb", 32'({cs[d], bwr[d], brd[d]}), 32'b101);
      check("rd1_addr", baddr[d], 32'h200);
    end
    m1_req = 1'b0;
    step(1);
    check("rd1_w0_rdv",  32'({m1_rdv[0], m0_rdv[0]}), 32'd2);
    check("rd1_w0_data", rd_data[0], 32'h1234_5678);
    check("rd1_w3_busy", 32'(busy[1]), 32'd1);
    check("rd1_w3_rd",   32'(brd[1]),  32'd0);
    check("rd1_w3_addr", baddr[1],     32'h200);
    step(3);
    check("rd1_w3_rdv",  32'({m1_rdv[1], m0_rdv[1]}), 32'd2);
    check("rd1_w3_data", rd_data[1], 32'h1234_5678);
    step(1);
    for (int d = 0; d < 2; d++) check("rd1_idle", 32'(busy[d]), 32'd0);

    // m0 read; bus data changes during the last WAIT cycle of the RD_WAIT=3 instance
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 32'h300; bus_rd_data = 32'h1;
    exp0_q.push_back('{m1: 1'b0, d: 32'h1});
    exp3_q.push_back('{m1: 1'b0, d: 32'hAA});
    step(1);
    for (int d = 0; d < 2; d++) begin
      check("rd2_gnt", 32'({m1_gnt[d], m0_gnt[d]}), 32'd1);
      check("rd2_rd",  32'(brd[d]), 32'd1);
    end
    m0_req = 1'b0;
    step(1);
    check("rd2_w0_data", rd_data[0], 32'h1);
    check("rd2_w3_rd_a", 32'(brd[1]), 32'd0);
    step(1);
    check("rd2_w3_rd_b",  32'(brd[1]), 32'd0);
    check("rd2_w3_early", 32'(m0_rdv[1]), 32'd0);
    step(1);
    check("rd2_w3_rd_c", 32'(brd[1]), 32'd0);
    bus_rd_data = 32'hAA;
    step(1);
    check("rd2_w3_rdv",  32'(m0_rdv[1]), 32'd1);
    check("rd2_w3_data", rd_data[1], 32'hAA);
    check("rd2_w0_hold", rd_data[0], 32'h1);
    step(1);
    check("rd2_w3_hold", rd_data[1], 32'hAA);
    check("rd2_w3_rdv0", 32'(m0_rdv[1]), 32'd0);

    // Reset while the RD_WAIT=3 instance sits in WAIT
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 32'h400; bus_rd_data = 32'h55;
    exp0_q.push_back('{m1: 1'b0, d: 32'h55});
    step(1);
    m0_req = 1'b0;
    step(2);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rstw_busy", 32'(busy[d]), 32'd0);
      check("rstw_strb", 32'({cs[d], bwr[d], brd[d]}), 32'd0);
      check("rstw_rdv",  32'({m1_rdv[d], m0_rdv[d]}), 32'd0);
    end
    step(1);
    rst_n = 1'b1;
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 32'h500;
    m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 32'h504;
    step(1);
    for (int d = 0; d < 2; d++) check("rstw_first_gnt", 32'({m1_gnt[d], m0_gnt[d]}), 32'd1);
    m0_req = 1'b0;
    step(2);
    for (int d = 0; d < 2; d++) check("rstw_second_gnt", 32'({m1_gnt[d], m0_gnt[d]}), 32'd2);
    m1_req = 1'b0;
    step(6);

    check("sb_pending0", 32'(exp0_q.size()), 32'd0);
    check("sb_pending3", 32'(exp3_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
